// File: rtl/hamming_host_sequencer.sv
`timescale 1ns/1ps
// Purpose : host-side initiator for the tt_um_hamming_top pin protocol (start, mode, data out; two result bytes in).
// Latency : pin_out=0x01 the cycle after accept; byte0/byte1 sampled 5+CAP_DLY / 6+CAP_DLY edges after accept; rsp_valid follows byte1.
// Backpr. : one request in flight; response held stable until rsp_ready, then GAP idle cycles before req_ready re-asserts.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset (shared with the chip)
//   req_valid/req_ready    request handshake; req_mode (0=encode, 1=decode), req_data[7:0]
//   rsp_valid/rsp_ready    response handshake; rsp_byte0, rsp_byte1, rsp_err
//   pin_out[7:0]           registered drive onto chip ui_in
//   pin_in[7:0]            chip uo_out
//   busy                   high from request accept until response handoff
module hamming_host_sequencer #(
  parameter int unsigned CAP_DLY = 0,
  parameter int unsigned GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_byte0,
  output logic [7:0] rsp_byte1,
  output logic       rsp_err,
  output logic [7:0] pin_out,
  input  logic [7:0] pin_in,
  output logic       busy
);

  // Shared counter for the WAIT and GAP phases; wide enough for CAP_DLY up to 255.
  localparam int unsigned CW = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_MODE,
    S_DATA,
    S_WAIT,
    S_CAP0,
    S_CAP1,
    S_RESP,
    S_GAP
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [7:0]    pin_d;
  logic          mode_q;
  logic [7:0]    data_q;
  logic          accept;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) && (state != S_GAP);
  assign accept    = req_valid && req_ready;

  // Next-state logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE:  if (req_valid) state_d = S_START;
      S_START: state_d = S_MODE;
      S_MODE:  state_d = S_DATA;
      S_DATA: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      // Pin round trip: one base cycle plus CAP_DLY pad/sync stages.
      S_WAIT: begin
        if (cnt == CW'(CAP_DLY)) state_d = S_CAP0;
        else                     cnt_d   = cnt + CW'(1);
      end
      S_CAP0: state_d = S_CAP1;
      S_CAP1: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          if (GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (cnt == CW'(GAP - 1)) state_d = S_IDLE;
        else                     cnt_d   = cnt + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // pin_out is registered alongside the state, so the value is chosen for the
  // state being entered. Anything outside START/MODE/DATA drives 0x00, which
  // keeps the chip from ever seeing a spurious start byte.
  always_comb begin
    pin_d = 8'h00;
    case (state_d)
      S_START: pin_d = 8'h01;
      S_MODE:  pin_d = {7'b0, mode_q};
      S_DATA:  pin_d = mode_q ? data_q : {4'h0, data_q[3:0]};
      default: pin_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pin_out   <= 8'h00;
      mode_q    <= 1'b0;
      data_q    <= 8'h00;
      rsp_byte0 <= 8'h00;
      rsp_byte1 <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pin_out <= pin_d;
      if (accept) begin
        mode_q <= req_mode;
        data_q <= req_data;
      end
      if (state == S_CAP0) begin
        rsp_byte0 <= pin_in;
      end
      if (state == S_CAP1) begin
        rsp_byte1 <= pin_in;
        // Encode: the chip repeats the codeword, so both bytes must agree.
        // Decode: byte1 is {3'b0, syndrome, errors}; the top bits must be clear.
        rsp_err   <= mode_q ? (pin_in[7:5] != 3'b000) : (pin_in != rsp_byte0);
      end
    end
  end

  pin_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !(state inside {S_START, S_MODE, S_DATA}) |-> (pin_out == 8'h00));

  rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_byte0)
                                   && $stable(rsp_byte1) && $stable(rsp_err)));

endmodule

// File: tb/tb_hamming_host_sequencer.sv
`timescale 1ns/1ps
module tb_hamming_host_sequencer;

  localparam int CAP_P = 0;
  localparam int GAP_P = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_mode;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_byte0;
  logic [7:0] rsp_byte1;
  logic       rsp_err;
  logic [7:0] pin_out;
  logic [7:0] pin_in;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  hamming_host_sequencer #(.CAP_DLY(CAP_P), .GAP(GAP_P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_byte0 (rsp_byte0),
    .rsp_byte1 (rsp_byte1),
    .rsp_err   (rsp_err),
    .pin_out   (pin_out),
    .pin_in    (pin_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // phase: 0 idle, 1 transaction in flight (accept..handoff), 2 post-handoff gap.
  int         phase = 0;
  int         cyc   = 0;
  int         t_acc = 0;
  int         t_h   = 0;
  logic       m_mode;
  logic [7:0] m_data;
  logic [7:0] m_b0;
  logic [7:0] m_b1;
  logic [7:0] s_b0;   // scripted chip reply bytes for the next transaction
  logic [7:0] s_b1;

  // Model of the request/response protocol plus a scripted chip: the chip
  // presents the two reply bytes only in the cycles they are to be captured,
  // and junk (0xEE) otherwise.
  initial begin
    int k;
    pin_in = 8'hEE;
    m_mode = 1'b0;
    m_data = 8'h00;
    m_b0   = 8'h00;
    m_b1   = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        phase  = 0;
        pin_in = 8'hEE;
      end else begin
        k = cyc - t_acc;
        cyc++;
        case (phase)
          0: if (req_valid) begin
               phase  = 1;
               t_acc  = cyc;
               m_mode = req_mode;
               m_data = req_data;
               m_b0   = s_b0;
               m_b1   = s_b1;
             end
          1: if (k >= 6 + CAP_P && rsp_ready) begin
               phase = (GAP_P == 0) ? 0 : 2;
               t_h   = cyc;
             end
          default: if (cyc - t_h >= GAP_P) phase = 0;
        endcase
        #1;
        k = cyc - t_acc;
        if (phase == 1 && k == 4 + CAP_P)      pin_in = m_b0;
        else if (phase == 1 && k == 5 + CAP_P) pin_in = m_b1;
        else                                   pin_in = 8'hEE;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    int         k;
    logic [7:0] e_pin;
    logic       e_vld;
    logic       e_err;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_pin_out", pin_out, 8'h00);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_byte0", rsp_byte0, 8'h00);
        chk("rst_rsp_byte1", rsp_byte1, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
      end else begin
        k     = cyc - t_acc;
        e_pin = 8'h00;
        if (phase == 1) begin
          if (k == 0)      e_pin = 8'h01;
          else if (k == 1) e_pin = {7'b0, m_mode};
          else if (k == 2) e_pin = m_mode ? m_data : {4'h0, m_data[3:0]};
        end
        e_vld = (phase == 1) && (k >= 6 + CAP_P);
        chk("pin_out", pin_out, e_pin);
        chk("req_ready", req_ready, phase == 0);
        chk("busy", busy, phase == 1);
        chk("rsp_valid", rsp_valid, e_vld);
        if (e_vld) begin
          e_err = m_mode ? (m_b1[7:5] != 3'b000) : (m_b0 != m_b1);
          chk("rsp_byte0", rsp_byte0, m_b0);
          chk("rsp_byte1", rsp_byte1, m_b1);
          chk("rsp_err", rsp_err, e_err);
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic run_txn(input logic mode, input logic [7:0] data,
                         input logic [7:0] b0, input logic [7:0] b1, input int hold,
                         input logic [31:0] e_pins, input logic [7:0] e0,
                         input logic [7:0] e1, input logic e_err);
    logic [31:0] pins;
    int n;
    int lat;
    s_b0 = b0;
    s_b1 = b1;
    @(negedge clk);
    req_mode  = mode;
    req_data  = data;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", n < 50, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    pins = {24'h0, pin_out};
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      pins = {pins[23:0], pin_out};
    end
    chk("pin_sequence", pins, e_pins);
    lat = 3;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, 6 + CAP_P);
    chk("lit_byte0", rsp_byte0, e0);
    chk("lit_byte1", rsp_byte1, e1);
    chk("lit_err", rsp_err, e_err);
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("hold_byte0", rsp_byte0, e0);
      chk("hold_ready", req_ready, 1'b0);
      chk("hold_pin", pin_out, 8'h00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("gap_ready_low", req_ready, 1'b0);
    chk("gap_pin_zero", pin_out, 8'h00);
    @(negedge clk);
    chk("ready_after_gap", req_ready, 1'b1);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_data  = 8'h00;
    rsp_ready = 1'b0;
    s_b0      = 8'h00;
    s_b1      = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Encode 0x0B, chip repeats 0x5A: consistent.
    run_txn(1'b0, 8'h0B, 8'h5A, 8'h5A, 0, 32'h01_00_0B_00, 8'h5A, 8'h5A, 1'b0);
    // Encode, mismatched repeat.
    run_txn(1'b0, 8'h0B, 8'h5A, 8'h5B, 0, 32'h01_00_0B_00, 8'h5A, 8'h5B, 1'b1);
    // Encode ignores the upper nibble of req_data.
    run_txn(1'b0, 8'hF9, 8'hC3, 8'hC3, 0, 32'h01_00_09_00, 8'hC3, 8'hC3, 1'b0);
    // Decode 0xC3: clean status byte, then a status byte with a top bit set.
    run_txn(1'b1, 8'hC3, 8'h03, 8'h1D, 0, 32'h01_01_C3_00, 8'h03, 8'h1D, 1'b0);
    run_txn(1'b1, 8'hC3, 8'h03, 8'h3D, 0, 32'h01_01_C3_00, 8'h03, 8'h3D, 1'b1);
    run_txn(1'b1, 8'h5A, 8'h09, 8'hE0, 0, 32'h01_01_5A_00, 8'h09, 8'hE0, 1'b1);
    // Back-pressure: response withheld for 10 cycles.
    run_txn(1'b0, 8'h06, 8'h66, 8'h66, 10, 32'h01_00_06_00, 8'h66, 8'h66, 1'b0);

    // Reset while the mode byte is on the pins.
    s_b0 = 8'h11;
    s_b1 = 8'h22;
    @(negedge clk);
    req_mode  = 1'b1;
    req_data  = 8'hC3;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mode_pin_before_rst", pin_out, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_pin_out", pin_out, 8'h00);
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_abort", seen, 0);
    run_txn(1'b0, 8'h0C, 8'hA5, 8'hA5, 2, 32'h01_00_0C_00, 8'hA5, 8'hA5, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
